// File: rtl/skylark_pkg.sv
// rtl/skylark_pkg.sv - shared execute-stage types for the multiply/divide unit
package skylark_pkg;

   typedef enum logic [2:0] {
      OP_MUL    = 3'b000,
      OP_MULH   = 3'b001,
      OP_MULHSU = 3'b010,
      OP_MULHU  = 3'b011,
      OP_DIV    = 3'b100,
      OP_DIVU   = 3'b101,
      OP_REM    = 3'b110,
      OP_REMU   = 3'b111
   } muldiv_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } muldiv_state_e;

endpackage

// File: rtl/muldiv_negate.sv
// rtl/muldiv_negate.sv - conditional two's-complement negate of a W-bit value
module muldiv_negate #(
   parameter int W = 32
) (
   input  logic         neg,
   input  logic [W-1:0] value,
   output logic [W-1:0] result
);

   assign result = neg ? (~value) + W'(1) : value;

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide, one bit per cycle, Z/N flags
module muldiv_unit
   import skylark_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            Z,
   output logic            N,
   output logic            busy
);

   localparam int CW = $clog2(XLEN);

   muldiv_state_e state, state_next;
   muldiv_op_e    op_in, op_q;
   logic [CW-1:0] cnt;
   logic          neg_a_q, neg_x_q;
   logic [XLEN-1:0] b_q, rem_q, result_q;
   logic [2*XLEN-1:0] acc;   // multiply: {hi, lo}; divide: lo shifts dividend out, quotient in
   logic          z_q, n_q;
   logic          accept, step, last, special;

   assign op_in = muldiv_op_e'(op);

   logic signed_a, signed_b, sign_a, sign_b;
   logic [XLEN-1:0] a_mag, b_mag;
   assign signed_a = (op_in == OP_MULH) || (op_in == OP_MULHSU) || (op_in == OP_DIV) || (op_in == OP_REM);
   assign signed_b = (op_in == OP_MULH) || (op_in == OP_DIV) || (op_in == OP_REM);
   assign sign_a   = signed_a & op_a[XLEN-1];
   assign sign_b   = signed_b & op_b[XLEN-1];

   muldiv_negate #(.W(XLEN)) u_neg_a (.neg(sign_a), .value(op_a), .result(a_mag));
   muldiv_negate #(.W(XLEN)) u_neg_b (.neg(sign_b), .value(op_b), .result(b_mag));

   // Divide-by-zero and signed overflow bypass the iteration entirely
   logic b_zero, sovf;
   logic [XLEN-1:0] special_res;
   assign b_zero  = (op_b == '0);
   assign sovf    = !op[0] && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
   assign special = op[2] && (b_zero || sovf);
   assign special_res = b_zero ? (op[1] ? op_a : '1) : (op[1] ? '0 : op_a);

   logic [XLEN:0]     mul_sum;
   logic [2*XLEN-1:0] mul_next, prod_fix;
   assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, b_q} : '0);
   assign mul_next = {mul_sum, acc[XLEN-1:1]};

   logic [XLEN:0]   div_shift;
   logic [XLEN-1:0] div_diff, rem_step, quo_step, quo_fix, rem_fix;
   logic            div_ok;
   assign div_shift = {rem_q, acc[XLEN-1]};
   assign div_ok    = (div_shift >= {1'b0, b_q});
   assign div_diff  = div_shift[XLEN-1:0] - b_q;
   assign rem_step  = div_ok ? div_diff : div_shift[XLEN-1:0];
   assign quo_step  = {acc[XLEN-2:0], div_ok};

   muldiv_negate #(.W(2*XLEN)) u_neg_p (.neg(neg_x_q), .value(mul_next), .result(prod_fix));
   muldiv_negate #(.W(XLEN))   u_neg_q (.neg(neg_x_q), .value(quo_step), .result(quo_fix));
   muldiv_negate #(.W(XLEN))   u_neg_r (.neg(neg_a_q), .value(rem_step), .result(rem_fix));

   logic [XLEN-1:0] final_res, res_next;
   always_comb begin
      final_res = rem_fix;
      case (op_q)
         OP_MUL:                       final_res = prod_fix[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod_fix[2*XLEN-1:XLEN];
         OP_DIV, OP_DIVU:              final_res = quo_fix;
         default:                      final_res = rem_fix;
      endcase
   end
   assign res_next = accept ? special_res : final_res;
   assign last     = (cnt == CW'(XLEN-1));

   always_comb begin
      state_next = state;
      accept     = 1'b0;
      step       = 1'b0;
      if (flush) begin
         state_next = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: if (in_valid) begin
               accept     = 1'b1;
               state_next = special ? ST_DONE : ST_CALC;
            end
            ST_CALC: begin
               step = 1'b1;
               if (last) state_next = ST_DONE;
            end
            ST_DONE: if (out_ready) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_next;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q     <= OP_MUL;
         cnt      <= '0;
         neg_a_q  <= 1'b0;
         neg_x_q  <= 1'b0;
         b_q      <= '0;
         rem_q    <= '0;
         acc      <= '0;
         result_q <= '0;
         z_q      <= 1'b1;
         n_q      <= 1'b0;
      end else begin
         if (accept) begin
            op_q    <= op_in;
            cnt     <= '0;
            neg_a_q <= sign_a;
            neg_x_q <= sign_a ^ sign_b;
            b_q     <= b_mag;
            rem_q   <= '0;
            acc     <= {{XLEN{1'b0}}, a_mag};
         end else if (step) begin
            cnt   <= cnt + CW'(1);
            rem_q <= rem_step;
            acc   <= op_q[2] ? {acc[2*XLEN-1:XLEN], quo_step} : mul_next;
         end
         if ((accept && special) || (step && last)) begin
            result_q <= res_next;
            z_q      <= (res_next == '0);
            n_q      <= res_next[XLEN-1];
         end
      end
   end

   assign in_ready  = (state == ST_IDLE);
   assign out_valid = (state == ST_DONE);
   assign busy      = (state != ST_IDLE);
   assign result    = result_q;
   assign Z         = z_q;
   assign N         = n_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed vector bench for muldiv_unit
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [2:0]  op = 3'b000;
   logic [31:0] op_a = '0;
   logic [31:0] op_b = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] result;
   logic        Z, N, busy;

   int passed = 0;
   int total  = 0;

   muldiv_unit #(.XLEN(32)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .op_a(op_a), .op_b(op_b),
      .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .Z(Z), .N(N), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic [7:0]  lat;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] r, input logic [7:0] l);
      vec_t v;
      v.op = o; v.a = a; v.b = b; v.res = r; v.lat = l;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   // Called at posedge+1; returns with out_valid high (or after the cycle budget)
   task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int lat);
      op = o; op_a = a; op_b = b; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic take_result();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   initial begin
      int   lat;
      logic stable, seen;

      vecs.push_back(mk(3'b000, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 8'd33));
      vecs.push_back(mk(3'b001, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 8'd33));
      vecs.push_back(mk(3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 8'd33));
      vecs.push_back(mk(3'b011, 32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF, 8'd33));
      vecs.push_back(mk(3'b000, 32'h12345678, 32'h00000010, 32'h23456780, 8'd33));
      vecs.push_back(mk(3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 8'd33));
      vecs.push_back(mk(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 8'd33));
      vecs.push_back(mk(3'b100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 8'd33));
      vecs.push_back(mk(3'b110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 8'd33));
      vecs.push_back(mk(3'b101, 32'd100,      32'd7,        32'd14,       8'd33));
      vecs.push_back(mk(3'b111, 32'd100,      32'd7,        32'd2,        8'd33));
      vecs.push_back(mk(3'b100, 32'd20,       32'hFFFFFFFD, 32'hFFFFFFFA, 8'd33));
      vecs.push_back(mk(3'b110, 32'd20,       32'hFFFFFFFD, 32'd2,        8'd33));
      vecs.push_back(mk(3'b101, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 8'd33));
      vecs.push_back(mk(3'b111, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 8'd33));
      vecs.push_back(mk(3'b101, 32'd1234,     32'd0,        32'hFFFFFFFF, 8'd1));
      vecs.push_back(mk(3'b100, 32'd9,        32'd0,        32'hFFFFFFFF, 8'd1));
      vecs.push_back(mk(3'b110, 32'd5,        32'd0,        32'd5,        8'd1));
      vecs.push_back(mk(3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 8'd1));
      vecs.push_back(mk(3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 8'd1));

      repeat (3) @(posedge clk);
      #1;
      check("rst in_ready", in_ready, 1);
      check("rst out_valid", out_valid, 0);
      check("rst busy", busy, 0);
      check("rst result", result, 0);
      check("rst Z", Z, 1);
      check("rst N", N, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      foreach (vecs[i]) begin
         check($sformatf("v%0d in_ready", i), in_ready, 1);
         do_op(vecs[i].op, vecs[i].a, vecs[i].b, lat);
         check($sformatf("v%0d latency", i), 32'(lat), 32'(vecs[i].lat));
         check($sformatf("v%0d result", i), result, vecs[i].res);
         check($sformatf("v%0d Z", i), Z, (vecs[i].res == 32'd0));
         check($sformatf("v%0d N", i), N, vecs[i].res[31]);
         take_result();
         check($sformatf("v%0d idle after take", i), in_ready, 1);
      end

      // Backpressure with ignored in_valid while DONE, then a back-to-back accept
      do_op(3'b000, 32'd3, 32'd5, lat);
      check("bp latency", 32'(lat), 33);
      stable = 1'b1;
      op = 3'b101; op_a = 32'd1; op_b = 32'd0; in_valid = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         if (result !== 32'd15 || in_ready !== 1'b0 || out_valid !== 1'b1) stable = 1'b0;
      end
      in_valid = 1'b0;
      check("bp held stable", stable, 1);
      check("bp result", result, 32'd15);
      take_result();
      check("bp in_ready", in_ready, 1);
      check("bp out_valid", out_valid, 0);
      do_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, lat);
      check("b2b latency", 32'(lat), 33);
      check("b2b result", result, 32'hFFFFFFFE);
      take_result();

      // Flush together with in_valid in IDLE is not an accept
      flush = 1'b1; in_valid = 1'b1; op = 3'b000; op_a = 32'd2; op_b = 32'd2;
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      check("flush+valid busy", busy, 0);
      check("flush+valid in_ready", in_ready, 1);

      // Flush in CALC cycle 5
      op = 3'b101; op_a = 32'd100; op_b = 32'd7; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("calc5 busy", busy, 1);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      check("flush out_valid", out_valid, 0);
      check("flush in_ready", in_ready, 1);
      check("flush busy", busy, 0);
      seen = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk); #1;
         if (out_valid) seen = 1'b1;
      end
      check("flush no result", seen, 0);

      // Flush with out_ready in DONE
      do_op(3'b101, 32'd9, 32'd0, lat);
      check("done latency", 32'(lat), 1);
      check("done result", result, 32'hFFFFFFFF);
      flush = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; out_ready = 1'b0;
      check("done flush out_valid", out_valid, 0);
      check("done flush in_ready", in_ready, 1);

      // Asynchronous reset mid-CALC
      op = 3'b000; op_a = 32'd7; op_b = 32'd7; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #2;
      check("arst in_ready", in_ready, 1);
      check("arst out_valid", out_valid, 0);
      check("arst busy", busy, 0);
      check("arst result", result, 0);
      check("arst Z", Z, 1);
      check("arst N", N, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      do_op(3'b000, 32'd6, 32'd7, lat);
      check("post-rst latency", 32'(lat), 33);
      check("post-rst result", result, 32'd42);
      take_result();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
